// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-coded symbol sequencer and its receive-side
// monitor: bus width, Gray/binary conversion helpers and decoder state type.
package gray_pkg;

    localparam int GRAY_W = 5;

    typedef enum logic [1:0] {
        UNLOCKED,
        LOCKED,
        FAULT
    } dec_state_t;

    // Width-generic: callers zero-extend into 32 bits and truncate the result.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down; leading zeros of a narrow code are harmless.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b     = '0;
        b[31] = g[31];
        for (int unsigned i = 31; i > 0; i--) begin
            b[i-1] = b[i] ^ g[i-1];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_state_decoder.sv
// Receive-side monitor for the Gray-encoded symbol sequencer. Registers the
// sequencer's state bus and parity bit, decodes the Gray code to a binary
// step index, tracks legal progress (hold or +1 mod 2^GRAY_W), counts laps and
// flags illegal jumps or parity mismatches.
module gray_state_decoder #(
    parameter int GRAY_W = gray_pkg::GRAY_W,
    parameter int LAP_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [GRAY_W-1:0] gray_in,
    input  logic              parity_in,
    input  logic              clear,
    output logic [GRAY_W-1:0] bin_out,
    output logic              locked,
    output logic              step,
    output logic              wrap,
    output logic [LAP_W-1:0]  lap_count,
    output logic              err_step,
    output logic              err_parity,
    output logic              err_sticky
);

    import gray_pkg::*;

    // Stage 1 registers
    logic [GRAY_W-1:0] r_g;
    logic              r_p;

    // Stage 2 registers
    dec_state_t        r_state;
    logic [GRAY_W-1:0] r_prev;
    logic [GRAY_W-1:0] r_bin;
    logic              r_step;
    logic              r_wrap;
    logic [LAP_W-1:0]  r_lap;
    logic              r_err_step;
    logic              r_err_parity;
    logic              r_err_sticky;

    // Stage 2 combinational results
    logic [GRAY_W-1:0] w_d;
    logic [GRAY_W-1:0] w_prev_inc;
    logic              w_pe;
    dec_state_t        w_state_nxt;
    logic [GRAY_W-1:0] w_prev_nxt;
    logic              w_step_nxt;
    logic              w_wrap_nxt;
    logic [LAP_W-1:0]  w_lap_nxt;
    logic              w_err_step_nxt;
    logic              w_err_parity_nxt;
    logic              w_sticky_nxt;

    assign w_d        = GRAY_W'(gray2bin(32'(r_g)));
    assign w_pe       = r_p != (^r_g[2:0]);
    assign w_prev_inc = r_prev + GRAY_W'(1);

    // Input capture stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_g <= '0;
            r_p <= 1'b0;
        end else begin
            r_g <= gray_in;
            r_p <= parity_in;
        end
    end

    // Next-state, pulse and status decision for the tracking FSM
    always_comb begin
        w_state_nxt      = r_state;
        w_prev_nxt       = (r_state == FAULT) ? r_prev : w_d;
        w_step_nxt       = 1'b0;
        w_wrap_nxt       = 1'b0;
        w_lap_nxt        = r_lap;
        w_err_step_nxt   = 1'b0;
        w_err_parity_nxt = 1'b0;
        w_sticky_nxt     = r_err_sticky;

        if (clear) begin
            w_state_nxt  = UNLOCKED;
            w_lap_nxt    = '0;
            w_sticky_nxt = 1'b0;
        end else begin
            case (r_state)
                UNLOCKED: begin
                    if ((w_d == '0) && !w_pe) begin
                        w_state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    if (w_pe) begin
                        w_err_parity_nxt = 1'b1;
                        w_sticky_nxt     = 1'b1;
                        w_state_nxt      = FAULT;
                    end else if (w_d == r_prev) begin
                        w_step_nxt = 1'b0;
                    end else if (w_d == w_prev_inc) begin
                        // The increment wraps naturally, so 31->0 lands here too.
                        w_step_nxt = 1'b1;
                        if (r_prev == '1) begin
                            w_wrap_nxt = 1'b1;
                            if (r_lap != '1) begin
                                w_lap_nxt = r_lap + LAP_W'(1);
                            end
                        end
                    end else begin
                        w_err_step_nxt = 1'b1;
                        w_sticky_nxt   = 1'b1;
                        w_state_nxt    = FAULT;
                    end
                end
                default: begin
                    w_state_nxt = FAULT;
                end
            endcase
        end
    end

    // Decode stage: state, history and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= UNLOCKED;
            r_prev       <= '0;
            r_bin        <= '0;
            r_step       <= 1'b0;
            r_wrap       <= 1'b0;
            r_lap        <= '0;
            r_err_step   <= 1'b0;
            r_err_parity <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_prev       <= w_prev_nxt;
            r_bin        <= w_d;
            r_step       <= w_step_nxt;
            r_wrap       <= w_wrap_nxt;
            r_lap        <= w_lap_nxt;
            r_err_step   <= w_err_step_nxt;
            r_err_parity <= w_err_parity_nxt;
            r_err_sticky <= w_sticky_nxt;
        end
    end

    assign bin_out    = r_bin;
    assign locked     = (r_state == LOCKED);
    assign step       = r_step;
    assign wrap       = r_wrap;
    assign lap_count  = r_lap;
    assign err_step   = r_err_step;
    assign err_parity = r_err_parity;
    assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_gray_state_decoder.sv
// Directed bench for gray_state_decoder with a behavioural reference model
// checked every cycle, plus literal expectations at the end of each scenario.
module tb_gray_state_decoder;

    localparam int GW   = 5;
    localparam int LW   = 2;
    localparam int NIDX = 32;
    localparam int LMAX = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [GW-1:0] gray_in = '0;
    logic          parity_in = 1'b0;
    logic          clear = 1'b0;
    logic [GW-1:0] bin_out;
    logic          locked;
    logic          step;
    logic          wrap;
    logic [LW-1:0] lap_count;
    logic          err_step;
    logic          err_parity;
    logic          err_sticky;

    gray_state_decoder #(.GRAY_W(GW), .LAP_W(LW)) dut (
        .clk        (clk),
        .reset      (reset),
        .gray_in    (gray_in),
        .parity_in  (parity_in),
        .clear      (clear),
        .bin_out    (bin_out),
        .locked     (locked),
        .step       (step),
        .wrap       (wrap),
        .lap_count  (lap_count),
        .err_step   (err_step),
        .err_parity (err_parity),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Inverse Gray lookup built from the forward definition i ^ (i >> 1)
    int g2b [NIDX];
    initial begin
        for (int i = 0; i < NIDX; i++) g2b[i ^ (i >> 1)] = i;
    end

    // Reference model: mode 0 = hunting for index 0, 1 = tracking, 2 = faulted
    int m_g1 = 0, m_p1 = 0, m_mode = 0, m_prev = 0;
    int e_bin = 0, e_step = 0, e_wrap = 0, e_lap = 0, e_es = 0, e_ep = 0, e_sticky = 0;

    always @(posedge clk or posedge reset) begin : model
        int d;
        int pe;
        if (reset) begin
            m_g1 <= 0; m_p1 <= 0; m_mode <= 0; m_prev <= 0;
            e_bin <= 0; e_step <= 0; e_wrap <= 0; e_lap <= 0;
            e_es <= 0; e_ep <= 0; e_sticky <= 0;
        end else begin
            d  = g2b[m_g1];
            pe = (m_p1 != ($countones(m_g1 % 8) % 2)) ? 1 : 0;
            e_bin  <= d;
            e_step <= 0; e_wrap <= 0; e_es <= 0; e_ep <= 0;
            if (m_mode != 2) m_prev <= d;
            if (clear) begin
                e_lap <= 0; e_sticky <= 0; m_mode <= 0;
            end else if (m_mode == 0) begin
                if (d == 0 && pe == 0) m_mode <= 1;
            end else if (m_mode == 1) begin
                if (pe != 0) begin
                    e_ep <= 1; e_sticky <= 1; m_mode <= 2;
                end else if (d == m_prev) begin
                    e_step <= 0;
                end else if (d == (m_prev + 1) % NIDX) begin
                    e_step <= 1;
                    if (d == 0) begin
                        e_wrap <= 1;
                        if (e_lap < LMAX) e_lap <= e_lap + 1;
                    end
                end else begin
                    e_es <= 1; e_sticky <= 1; m_mode <= 2;
                end
            end
            m_g1 <= int'(gray_in);
            m_p1 <= int'(parity_in);
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            chk("bin_out",    int'(bin_out),    e_bin);
            chk("locked",     int'(locked),     (m_mode == 1) ? 1 : 0);
            chk("step",       int'(step),       e_step);
            chk("wrap",       int'(wrap),       e_wrap);
            chk("lap_count",  int'(lap_count),  e_lap);
            chk("err_step",   int'(err_step),   e_es);
            chk("err_parity", int'(err_parity), e_ep);
            chk("err_sticky", int'(err_sticky), e_sticky);
        end
    end

    // Pulse tallies observed on the DUT, used by the literal scenario checks
    int n_step = 0, n_wrap = 0, n_es = 0, n_ep = 0;
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            n_step += int'(step);
            n_wrap += int'(wrap);
            n_es   += int'(err_step);
            n_ep   += int'(err_parity);
        end
    end

    task automatic put(input int idx, input bit good, input int cyc);
        logic [GW-1:0] g;
        @(negedge clk);
        g         = GW'(idx ^ (idx >> 1));
        gray_in   = g;
        parity_in = (^g[2:0]) ^ !good;
        repeat (cyc - 1) @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic run_laps(input int laps);
        for (int l = 0; l < laps; l++) begin
            for (int i = 1; i < NIDX; i++) put(i, 1'b1, 1);
            put(0, 1'b1, 1);
        end
    endtask

    int bs, bw, be, bp;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_bin_out",    int'(bin_out),    0);
        chk("rst_locked",     int'(locked),     0);
        chk("rst_lap_count",  int'(lap_count),  0);
        chk("rst_err_sticky", int'(err_sticky), 0);
        reset = 1'b0;

        // One full lap, two cycles per value
        bs = n_step; bw = n_wrap; be = n_es + n_ep;
        for (int i = 1; i < NIDX; i++) put(i, 1'b1, 2);
        put(0, 1'b1, 2);
        repeat (3) @(negedge clk);
        chk("lap_steps",  n_step - bs, 32);
        chk("lap_wraps",  n_wrap - bw, 1);
        chk("lap_count1", int'(lap_count), 1);
        chk("lap_locked", int'(locked), 1);
        chk("lap_errors", n_es + n_ep - be, 0);

        // Parity error while tracking at index 3
        put(1, 1'b1, 2); put(2, 1'b1, 2); put(3, 1'b1, 2);
        repeat (2) @(negedge clk);
        chk("par_pre_locked", int'(locked), 1);
        bs = n_step; bp = n_ep;
        put(4, 1'b0, 2);
        repeat (2) @(negedge clk);
        chk("par_pulses", n_ep - bp, 1);
        chk("par_sticky", int'(err_sticky), 1);
        chk("par_locked", int'(locked), 0);
        chk("par_steps",  n_step - bs, 0);

        // Illegal jump 5 -> 9 after clearing and relocking
        pulse_clear();
        for (int i = 0; i <= 5; i++) put(i, 1'b1, 2);
        repeat (2) @(negedge clk);
        chk("jmp_pre_locked", int'(locked), 1);
        be = n_es;
        put(9, 1'b1, 2);
        @(negedge clk);
        chk("jmp_bin_out",  int'(bin_out), 9);
        chk("jmp_err_step", int'(err_step), 1);
        repeat (2) @(negedge clk);
        chk("jmp_pulses", n_es - be, 1);
        chk("jmp_locked", int'(locked), 0);
        chk("jmp_sticky", int'(err_sticky), 1);

        // Clear out of FAULT, relock only on index 0
        pulse_clear();
        chk("clr_sticky", int'(err_sticky), 0);
        chk("clr_lap",    int'(lap_count), 0);
        put(7, 1'b1, 2);
        @(negedge clk);
        chk("clr_idx7_locked", int'(locked), 0);
        put(0, 1'b1, 2);
        @(negedge clk);
        chk("clr_idx0_locked", int'(locked), 1);

        // Five back-to-back laps saturate a 2-bit lap counter
        bw = n_wrap;
        run_laps(5);
        repeat (3) @(negedge clk);
        chk("sat_wraps", n_wrap - bw, 5);
        chk("sat_lap",   int'(lap_count), LMAX);

        // Asynchronous reset while tracking at index 17 with two laps
        pulse_clear();
        repeat (2) @(negedge clk);
        run_laps(2);
        for (int i = 1; i <= 17; i++) put(i, 1'b1, 1);
        repeat (3) @(negedge clk);
        chk("pre_rst_lap",    int'(lap_count), 2);
        chk("pre_rst_bin",    int'(bin_out), 17);
        chk("pre_rst_locked", int'(locked), 1);
        @(negedge clk);
        #2;
        reset     = 1'b1;
        gray_in   = '0;
        parity_in = 1'b0;
        #1;
        chk("arst_bin_out",    int'(bin_out),    0);
        chk("arst_locked",     int'(locked),     0);
        chk("arst_step",       int'(step),       0);
        chk("arst_wrap",       int'(wrap),       0);
        chk("arst_lap_count",  int'(lap_count),  0);
        chk("arst_err_step",   int'(err_step),   0);
        chk("arst_err_parity", int'(err_parity), 0);
        chk("arst_err_sticky", int'(err_sticky), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_locked", int'(locked), 1);
        chk("post_rst_bin",    int'(bin_out), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
